// File: rtl/alu_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_pipe
// Purpose  : Execute-to-memory pipeline stage that sits right after the ALU.
//            A 2-entry skid buffer (main + skid) holds the ALU result, its
//            flags and the destination tag. Valid/ready handshakes are used
//            on both sides. The architectural NZCV register is updated when
//            a flag-setting op retires. A saturating counter tracks retired
//            ops that overflowed.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            in_valid/in_ready             - upstream handshake (ready is
//                                            registered)
//            in_resultado, in_rd, in_we    - ALU result, dest tag, RF write
//            in_cout/zero/neg/overflow     - ALU flags
//            in_set_flags                  - op updates NZCV on retire
//            flush                         - squash all buffered entries
//            out_valid/out_ready           - downstream handshake
//            out_resultado, out_rd, out_we - head entry fields
//            out_flags                     - head flags {neg,zero,cout,ovf}
//            nzcv_q                        - architectural flags {N,Z,C,V}
//            ovf_count                     - saturating overflow retire count
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_pipe #(
  parameter int N     = 32,
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_resultado,
  input  logic             in_cout,
  input  logic             in_zero,
  input  logic             in_neg,
  input  logic             in_overflow,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_we,
  input  logic             in_set_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_resultado,
  output logic [REG_W-1:0] out_rd,
  output logic             out_we,
  output logic [3:0]       out_flags,
  output logic [3:0]       nzcv_q,
  output logic [CNT_W-1:0] ovf_count
);

  // Entry layout: {result, rd, we, set_flags, neg, zero, cout, overflow}
  localparam int ENT_W = N + REG_W + 6;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ENT_W-1:0]   r_main;
  logic [ENT_W-1:0]   r_skid;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [3:0]         r_nzcv;
  logic [CNT_W-1:0]   r_ovf_count;

  logic [ENT_W-1:0]   w_in_ent;
  logic               w_acc;
  logic               w_ret;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_in_ent = {in_resultado, in_rd, in_we, in_set_flags,
                     in_neg, in_zero, in_cout, in_overflow};

  // An input offered during a flush is discarded, so it never counts as
  // accepted. A retire still completes in the flush cycle.
  assign w_acc = in_valid & r_in_ready & ~flush;
  assign w_ret = r_out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Occupancy FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy FSM: next state and entry load controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt    = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && !w_ret) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (!w_acc && w_ret) begin
          w_state_nxt = EMPTY;
        end else if (w_acc && w_ret) begin
          w_load_main_in = 1'b1;
        end
      end
      FULL: begin
        // in_ready is low here, so no accept can coincide with the retire.
        if (w_ret) begin
          w_state_nxt      = ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt      = EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage and registered handshake outputs. Main is left untouched
  // when it is not reloaded, which keeps out_* stable under backpressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_ent;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_ent;
      end
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  // --------------------------------------------------------------------------
  // Retire side effects: NZCV update and saturating overflow counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nzcv      <= 4'd0;
      r_ovf_count <= '0;
    end else if (w_ret) begin
      if (r_main[4]) begin
        r_nzcv <= r_main[3:0];
      end
      if (r_main[0] && (r_ovf_count != C_CNT_MAX)) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_resultado = r_main[ENT_W-1 -: N];
  assign out_rd        = r_main[REG_W+5:6];
  assign out_we        = r_main[5];
  assign out_flags     = r_main[3:0];
  assign nzcv_q        = r_nzcv;
  assign ovf_count     = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_pipe
// Purpose  : Directed self-checking bench for alu_result_pipe (CNT_W=2 so the
//            overflow counter saturates within a short run).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_pipe;

  localparam int N     = 32;
  localparam int REG_W = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_resultado;
  logic             in_cout, in_zero, in_neg, in_overflow;
  logic [REG_W-1:0] in_rd;
  logic             in_we;
  logic             in_set_flags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_resultado;
  logic [REG_W-1:0] out_rd;
  logic             out_we;
  logic [3:0]       out_flags;
  logic [3:0]       nzcv_q;
  logic [CNT_W-1:0] ovf_count;

  int n_checks = 0;
  int n_fails  = 0;

  alu_result_pipe #(.N(N), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_resultado  (in_resultado),
    .in_cout       (in_cout),
    .in_zero       (in_zero),
    .in_neg        (in_neg),
    .in_overflow   (in_overflow),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .in_set_flags  (in_set_flags),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_resultado (out_resultado),
    .out_rd        (out_rd),
    .out_we        (out_we),
    .out_flags     (out_flags),
    .nzcv_q        (nzcv_q),
    .ovf_count     (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags argument is {neg, zero, cout, overflow}
  task automatic drive(input logic v, input logic [N-1:0] d, input logic [REG_W-1:0] rd,
                       input logic we, input logic sf, input logic [3:0] fl);
    in_valid     = v;
    in_resultado = d;
    in_rd        = rd;
    in_we        = we;
    in_set_flags = sf;
    {in_neg, in_zero, in_cout, in_overflow} = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    repeat (2) tick();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_res", out_resultado, 32'd0);
    chk("rst_nzcv", 32'(nzcv_q), 32'd0);
    chk("rst_ovf", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;

    // Single op, 1-cycle latency, flags update on retire
    out_ready = 1'b1;
    drive(1'b1, 32'h5, 4'd3, 1'b1, 1'b1, 4'b0010);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_res", out_resultado, 32'h5);
    chk("single_rd", 32'(out_rd), 32'd3);
    chk("single_we", 32'(out_we), 32'd1);
    chk("single_flags", 32'(out_flags), 32'b0010);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("single_nzcv", 32'(nzcv_q), 32'b0010);
    chk("single_empty", 32'(out_valid), 32'd0);

    // Backpressure fill
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 4'd1, 1'b1, 1'b0, 4'b0000);
    tick();
    chk("bp_A_valid", 32'(out_valid), 32'd1);
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h22, 4'd2, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_A", out_resultado, 32'h11);
    drive(1'b1, 32'h33, 4'd7, 1'b1, 1'b0, 4'b0000);
    tick();
    chk("bp_still_A", out_resultado, 32'h11);
    chk("bp_still_rd", 32'(out_rd), 32'd1);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    out_ready = 1'b1;
    tick();
    chk("bp_B_res", out_resultado, 32'h22);
    chk("bp_B_rd", 32'(out_rd), 32'd2);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Streaming, 1 op/cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 4'(i), 1'b1, 1'b0, 4'b0000);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_res", out_resultado, 32'(i));
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("stream_end", 32'(out_valid), 32'd0);

    // Flag gating
    drive(1'b1, 32'h40, 4'd4, 1'b1, 1'b1, 4'b1000);
    tick();
    drive(1'b1, 32'h0, 4'd5, 1'b1, 1'b0, 4'b0100);
    tick();
    chk("gate_nzcv_set", 32'(nzcv_q), 32'b1000);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("gate_nzcv_hold", 32'(nzcv_q), 32'b1000);

    // Flush with FULL buffer, head retires in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 4'd6, 1'b1, 1'b1, 4'b0100);
    tick();
    drive(1'b1, 32'h60, 4'd7, 1'b1, 1'b1, 4'b0010);
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h70, 4'd8, 1'b1, 1'b1, 4'b0001);
    tick();
    chk("fl_nzcv", 32'(nzcv_q), 32'b0100);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("fl_dropped", 32'(out_valid), 32'd0);
    chk("fl_ovf", 32'(ovf_count), 32'd0);

    // Flush in ONE with an input offered while in_ready=1: offered op dropped
    out_ready = 1'b0;
    drive(1'b1, 32'h80, 4'd9, 1'b1, 1'b1, 4'b1001);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h90, 4'd10, 1'b1, 1'b1, 4'b1001);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    chk("fl1_empty", 32'(out_valid), 32'd0);
    tick();
    chk("fl1_still_empty", 32'(out_valid), 32'd0);
    chk("fl1_nzcv", 32'(nzcv_q), 32'b0100);
    chk("fl1_ovf", 32'(ovf_count), 32'd0);

    // Saturating overflow counter (CNT_W=2)
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'(k), 4'd1, 1'b0, 1'b0, 4'b0001);
      tick();
      chk("ovf_count", 32'(ovf_count), (k - 1 > 3) ? 32'd3 : 32'(k - 1));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("ovf_sat", 32'(ovf_count), 32'd3);
    tick();
    chk("ovf_sat_hold", 32'(ovf_count), 32'd3);

    // Async reset mid-stream, checked between clock edges
    out_ready = 1'b0;
    drive(1'b1, 32'hA5, 4'd11, 1'b1, 1'b1, 4'b1111);
    tick();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_out_res", out_resultado, 32'd0);
    chk("ar_out_rd", 32'(out_rd), 32'd0);
    chk("ar_out_we", 32'(out_we), 32'd0);
    chk("ar_out_flags", 32'(out_flags), 32'd0);
    chk("ar_nzcv", 32'(nzcv_q), 32'd0);
    chk("ar_ovf", 32'(ovf_count), 32'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_pipe.md
Name: alu_result_pipe

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Captures the ALU result word, its cout/zero/neg/overflow flags and the destination tag into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Maintains the architectural NZCV flags register, updated only when a flag-setting op retires from the output.
- Counts retired ops that overflowed; the counter feeds debug.

Parameters:
- N, 32, datapath width; matches ALU result width.
- REG_W, 4, destination register tag width.
- CNT_W, 16, overflow event counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU output holds a valid op
- in_ready  out  1  stage can accept; registered, equals NOT skid_full
- in_resultado  in  N  ALU result
- in_cout, in_zero, in_neg, in_overflow  in  1 each  ALU flags
- in_rd  in  REG_W  destination register tag
- in_we  in  1  op writes register file
- in_set_flags  in  1  op updates NZCV on retire
- flush  in  1  synchronous squash of all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts head
- out_resultado  out  N  head result
- out_rd  out  REG_W  head tag
- out_we  out  1  head write enable
- out_flags  out  4  head flags {neg, zero, cout, overflow}
- nzcv_q  out  4  architectural flags {N, Z, C, V}
- ovf_count  out  CNT_W  saturating count of retired ops with overflow=1

Behaviour:
- Reset (rst_n=0, asynchronous): both entries invalid; out_valid=0, in_ready=1, out_resultado=0, out_rd=0, out_we=0, out_flags=0, nzcv_q=0, ovf_count=0.
- Transfers: input accepted when in_valid AND in_ready at the clock edge; output retires when out_valid AND out_ready. Outputs are driven only from registers, with no combinational path from in_* to out_*.
- States (by occupancy):
  - EMPTY: accept -> ONE (main entry).
  - ONE: accept and no retire -> FULL (new op in skid). Retire and no accept -> EMPTY. Accept and retire -> ONE, with the new op in main.
  - FULL: in_ready=0. Retire -> ONE, with the skid entry moved to main the same edge.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Stability: while out_valid=1 and out_ready=0, every out_* stays constant.
- Latency: 1 cycle from input accept to out_valid with an empty buffer. Full throughput of 1 op/cycle when out_ready stays high.
- Retire side effects:
  - If in_set_flags of the retiring op was 1, nzcv_q <= its {neg, zero, cout, overflow} on that edge. Otherwise nzcv_q holds.
  - If the retiring op has overflow=1, ovf_count increments and saturates at 2^CNT_W-1.
  - Side effects apply regardless of the set_flags/we values of other entries.
- Flush:
  - Next state is EMPTY; any input offered in the flush cycle is discarded.
  - A retire handshake completing in the flush cycle still counts: its nzcv_q and ovf_count updates happen.
  - in_ready=1 the cycle after flush.
- Reset asserted mid-operation: immediate clear to reset values; no partial retire.
- Data width: fields are stored verbatim, with no sign or zero extension.
- Flag storage: out_flags and nzcv_q are stored from the captured flags, not recomputed.

Test Plan:
- Reset then a single op: in_resultado=0x0000_0005, rd=3, we=1, set_flags=1, flags neg=0 zero=0 cout=1 overflow=0; out_ready=1.
  -> out_valid the next cycle with 0x5 and rd=3; nzcv_q=4'b0010 after retire.
- Backpressure fill: out_ready=0, offer ops A=0x11 then B=0x22.
  -> in_ready=0 after B; out holds A stable.
  -> Release out_ready: A, then B on consecutive cycles; in_ready=1 again.
- Streaming: 8 back-to-back ops 0x1..0x8 with out_ready=1.
  -> 8 retires in 8 consecutive cycles, in order, with no bubbles.
- Flag gating: op with set_flags=0 and zero=1 retires after an op setting nzcv=4'b1000.
  -> nzcv_q stays 4'b1000.
- Flush with FULL buffer while out_ready=1 and an input is offered.
  -> Head retires and updates flags; the other entry and the offered input are dropped; out_valid=0 next cycle.
- Overflow counter: CNT_W=2, retire 5 ops with overflow=1.
  -> ovf_count reaches 3 and stays 3.
  -> Async rst_n pulse mid-stream: all outputs at reset values without waiting for a clock edge.
